// File: rtl/grid_serializer_if.sv
// Bit-stream channel between the grid serializer and its downstream consumer.
// The serializer is the master; the consumer supplies backpressure through out_ready.
interface grid_serializer_if;
   logic out_valid;
   logic out_ready;
   logic out_bit;
   logic out_sof;
   logic out_eol;
   logic out_eof;

   modport master (
      output out_valid, out_bit, out_sof, out_eol, out_eof,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_bit, out_sof, out_eol, out_eof,
      output out_ready
   );
endinterface

// File: rtl/grid_serializer.sv
// Snapshots a ROWS x COLS cell grid and streams it row-major, one bit per accepted
// transfer, with frame/line markers and a live-cell count reported at frame end.
module grid_serializer #(
   parameter  int ROWS  = 16,
   parameter  int COLS  = 16,
   localparam int CNT_W = $clog2(ROWS * COLS + 1),
   localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1,
   localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [ROWS-1:0][COLS-1:0]  grid,
   input  logic                       start,
   output logic                       busy,
   output logic [CNT_W-1:0]           pop_count,
   output logic                       pop_valid,
   grid_serializer_if.master          stream
);

   typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

   state_t                      state_r;
   state_t                      state_s;
   logic [ROWS-1:0][COLS-1:0]   shadow_r;
   logic [ROW_W-1:0]            row_r;
   logic [COL_W-1:0]            col_r;
   logic [CNT_W-1:0]            acc_r;
   logic [CNT_W-1:0]            pop_count_r;
   logic                        valid_s;
   logic                        bit_s;
   logic                        row_end_s;
   logic                        last_s;
   logic                        xfer_s;

   assign valid_s   = (state_r == SEND);
   assign row_end_s = (col_r == COL_W'(COLS - 1));
   assign last_s    = row_end_s && (row_r == ROW_W'(ROWS - 1));
   assign bit_s     = valid_s ? shadow_r[row_r][col_r] : 1'b0;
   assign xfer_s    = valid_s && stream.out_ready;

   // Markers are qualified by valid so the channel is all-zero outside SEND.
   assign stream.out_valid = valid_s;
   assign stream.out_bit   = bit_s;
   assign stream.out_sof   = valid_s && (row_r == ROW_W'(0)) && (col_r == COL_W'(0));
   assign stream.out_eol   = valid_s && row_end_s;
   assign stream.out_eof   = valid_s && last_s;

   assign busy      = (state_r != IDLE);
   assign pop_valid = (state_r == DONE);
   assign pop_count = pop_count_r;

   // Next-state decode.
   always_comb begin
      state_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) state_s = SEND;
            else       state_s = IDLE;
         end
         SEND: begin
            if (xfer_s && last_s) state_s = DONE;
            else                  state_s = SEND;
         end
         DONE:    state_s = IDLE;
         default: state_s = IDLE;
      endcase
   end

   // State, snapshot, scan indices and live-cell accumulation.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r     <= IDLE;
         shadow_r    <= '0;
         row_r       <= '0;
         col_r       <= '0;
         acc_r       <= '0;
         pop_count_r <= '0;
      end else begin
         state_r <= state_s;
         case (state_r)
            IDLE: begin
               if (start) begin
                  shadow_r <= grid;
                  row_r    <= '0;
                  col_r    <= '0;
                  acc_r    <= '0;
               end
            end
            SEND: begin
               if (xfer_s) begin
                  acc_r <= acc_r + CNT_W'(bit_s);
                  if (last_s) begin
                     row_r       <= '0;
                     col_r       <= '0;
                     pop_count_r <= acc_r + CNT_W'(bit_s);
                  end else if (row_end_s) begin
                     row_r <= row_r + ROW_W'(1);
                     col_r <= '0;
                  end else begin
                     col_r <= col_r + COL_W'(1);
                  end
               end
            end
            DONE: begin
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: doc/grid_serializer.md
GRID_SERIALIZER -- requirements
Module: grid_serializer

Interface
REQ-001 Parameter ROWS, default 16, number of grid rows.
REQ-002 Parameter COLS, default 16, number of grid columns.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-005 grid  input  [ROWS-1:0][COLS-1:0]  live cell array; grid[r][c]=1 means cell alive.
REQ-006 start  input  1  request to snapshot and stream one frame.
REQ-007 busy  output  1  high from snapshot until return to IDLE.
REQ-008 out_valid  output  1  out_bit/markers are valid.
REQ-009 out_ready  input  1  downstream accepts the current bit.
REQ-010 out_bit  output  1  cell value being transmitted.
REQ-011 out_sof  output  1  high with the first bit of a frame (r=0,c=0).
REQ-012 out_eol  output  1  high with the last bit of each row (c=COLS-1).
REQ-013 out_eof  output  1  high with the last bit of the frame (r=ROWS-1,c=COLS-1).
REQ-014 pop_count  output  9 (defaults)  number of live cells in the last completed frame, 0..256.
REQ-015 pop_valid  output  1  one-cycle pulse when pop_count updates.

Function
REQ-016 States SHALL be IDLE, SEND, DONE.
REQ-017 IDLE: start=1 SHALL copy grid into an internal shadow array, clear row/col indices and the live-cell accumulator, and enter SEND on the next edge.
REQ-018 Streamed data SHALL come from the shadow array only; changes on grid after the snapshot SHALL NOT affect the frame in flight.
REQ-019 SEND: out_valid=1; out_bit=shadow[row][col]; markers decoded combinationally from row/col.
REQ-020 Transfer occurs on a rising edge with out_valid=1 and out_ready=1; only then SHALL col advance, and the accumulator add out_bit.
REQ-021 Order: row 0 to ROWS-1; within a row, col 0 to COLS-1; col wraps COLS-1 to 0 with row+1.
REQ-022 out_ready=0 SHALL stall: out_bit, out_sof, out_eol, out_eof, indices and accumulator held unchanged.
REQ-023 First bit SHALL be presented the cycle after start is sampled (1-cycle latency); a frame with continuous out_ready SHALL take exactly ROWS*COLS cycles in SEND.
REQ-024 Transfer of the out_eof bit SHALL enter DONE; the accumulator value including that bit SHALL load into pop_count.
REQ-025 DONE lasts exactly one cycle: pop_valid=1, out_valid=0, busy=1; then IDLE.
REQ-026 start while in SEND or DONE SHALL be ignored (no queuing); start held high in IDLE after DONE SHALL begin a new frame.
REQ-027 pop_count SHALL hold its value until the next DONE; width SHALL hold ROWS*COLS without overflow (all-alive = 256).
REQ-028 out_sof, out_eol, out_eof, out_bit SHALL be 0 whenever out_valid=0.
REQ-029 busy=0 only in IDLE.

Reset
REQ-030 reset=1 SHALL force IDLE from any state, including mid-frame, discarding the frame in flight.
REQ-031 Reset values: busy=0, out_valid=0, out_bit=0, out_sof=0, out_eol=0, out_eof=0, pop_count=0, pop_valid=0, indices=0, accumulator=0.
REQ-032 reset SHALL take priority over start in the same cycle.

Verification
REQ-033 Empty grid, start pulse, out_ready=1 -> 256 bits all 0, sof on bit 0, eol on bits 15,31,..,255, eof on bit 255, pop_valid pulse with pop_count=0.
REQ-034 Vertical blinker grid[7][8],grid[8][8],grid[9][8]=1, out_ready=1 -> ones exactly at bit indices 120,136,152; pop_count=3.
REQ-035 All-alive grid, out_ready toggling 1/0 every cycle -> 256 ones, outputs stable across stalls, frame completes in 511 cycles, pop_count=256.
REQ-036 Snapshot blinker, then change grid to horizontal blinker during SEND -> stream still vertical (bits 120,136,152); next start streams bits 135,136,137.
REQ-037 start pulsed during SEND at bit 40 -> ignored, single frame, single pop_valid pulse.
REQ-038 reset asserted at bit 100 of an all-alive frame -> next cycle IDLE, out_valid=0, pop_count=0, no pop_valid; fresh start then streams a full frame from bit 0.
